// File: rtl/moore_toggle_divider_if.sv
// Control/status bundle for moore_toggle_divider.
// Rev 1.0 - initial release.
`default_nettype none

interface moore_toggle_divider_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_n;
  logic [CH-1:0]    din;
  logic [CH-1:0]    dout;
  logic [CH-1:0]    toggle_pulse;
  logic [2*CH-1:0]  state_dbg;

  modport master (
    output en, div_n, din,
    input  dout, toggle_pulse, state_dbg
  );

  modport slave (
    input  en, div_n, din,
    output dout, toggle_pulse, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/moore_toggle_divider.sv
// ---------------------------------------------------------------------------
// moore_toggle_divider : bank of CH Moore toggle FSMs, divide-by-N per channel
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module moore_toggle_divider #(
  parameter int CH        = 4,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  moore_toggle_divider_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_S0   = 2'b01;
  localparam logic [1:0] ST_S1   = 2'b10;

  logic [CH-1:0][1:0]       state_q, state_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]            pulse_q, pulse_d;
  logic [CH-1:0]            din_q, din_d;
  logic [CNT_W-1:0]         div_l_q, div_l_d;

  logic [CH-1:0]            evt;
  logic [CNT_W-1:0]         div_m1;
  logic                     all_idle;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      din_q   <= '0;
      div_l_q <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      din_q   <= din_d;
      div_l_q <= div_l_d;
    end
  end

  // Next-state logic
  always_comb begin
    evt      = (EDGE_MODE != 0) ? (bus.din & ~din_q) : bus.din;
    div_m1   = div_l_q - CNT_W'(1);
    all_idle = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (state_q[i] != ST_IDLE) all_idle = 1'b0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    din_d   = bus.din;

    // div_n is captured only when the whole bank is leaving IDLE together
    div_l_d = div_l_q;
    if (bus.en && all_idle) begin
      div_l_d = (bus.div_n == '0) ? CNT_W'(1) : bus.div_n;
    end

    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (bus.en) state_d[i] = ST_S0;
        end
        ST_S0, ST_S1: begin
          if (!bus.en) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (evt[i]) begin
            if (cnt_q[i] == div_m1) begin
              state_d[i] = (state_q[i] == ST_S0) ? ST_S1 : ST_S0;
              cnt_d[i]   = '0;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    bus.dout         = '0;
    bus.state_dbg    = '0;
    bus.toggle_pulse = pulse_q;
    for (int i = 0; i < CH; i++) begin
      bus.dout[i]           = (state_q[i] == ST_S1);
      bus.state_dbg[2*i +: 2] = state_q[i];
    end
  end

endmodule

`default_nettype wire
